id_ex_register: RTL and testbench

ID/EX pipeline register of the five-stage MIPS datapath. It sits directly downstream of the main control decoder and captures that decoder's 9-bit control word together with the decode-stage operands. It also owns load-use hazard detection:
- it raises a stall to the PC and IF/ID registers;
- it inserts a bubble into EX;
- it honours a branch flush and an external hold.

---
 rtl/id_ex_register.sv | 156 +++++++++++++++
 tb/tb_id_ex_register.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/id_ex_register.sv
// rtl/id_ex_register.sv - ID/EX pipeline register with load-use stall/bubble; optional bubble counter under ID_EX_BUBBLE_CNT_EN
module id_ex_register #(
  parameter int DATA_W = 32,
  parameter int REG_W  = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [8:0]        controlData,
  input  logic              idValid,
  input  logic [DATA_W-1:0] readData1,
  input  logic [DATA_W-1:0] readData2,
  input  logic [DATA_W-1:0] signExtImm,
  input  logic [DATA_W-1:0] pcPlus4,
  input  logic [REG_W-1:0]  idRs,
  input  logic [REG_W-1:0]  idRt,
  input  logic [REG_W-1:0]  idRd,
  input  logic              flush,
  input  logic              hold,
  output logic [8:0]        exControl,
  output logic              exValid,
  output logic [DATA_W-1:0] exReadData1,
  output logic [DATA_W-1:0] exReadData2,
  output logic [DATA_W-1:0] exImm,
  output logic [DATA_W-1:0] exPcPlus4,
  output logic [REG_W-1:0]  exRs,
  output logic [REG_W-1:0]  exRt,
  output logic [REG_W-1:0]  exRd,
  output logic              stall,
  output logic [15:0]       bubbleCount
);

  localparam int MEMREAD_BIT = 4;

  logic [8:0]        ctrl_q, ctrl_d;
  logic              valid_q, valid_d;
  logic [DATA_W-1:0] rd1_q, rd1_d;
  logic [DATA_W-1:0] rd2_q, rd2_d;
  logic [DATA_W-1:0] imm_q, imm_d;
  logic [DATA_W-1:0] pc_q, pc_d;
  logic [REG_W-1:0]  rs_q, rs_d;
  logic [REG_W-1:0]  rt_q, rt_d;
  logic [REG_W-1:0]  rd_q, rd_d;
  logic              hazard;

  // Load in EX whose destination ($rt, never $zero) is a source of the ID instruction
  always_comb begin
    hazard = valid_q & ctrl_q[MEMREAD_BIT] & (rt_q != '0) & idValid &
             ((rt_q == idRs) | (rt_q == idRt));
  end

  assign stall = hazard & ~flush;

  // Next state, priority flush > hold > hazard bubble > normal load
  always_comb begin
    ctrl_d  = ctrl_q;
    valid_d = valid_q;
    rd1_d   = rd1_q;
    rd2_d   = rd2_q;
    imm_d   = imm_q;
    pc_d    = pc_q;
    rs_d    = rs_q;
    rt_d    = rt_q;
    rd_d    = rd_q;
    if (flush) begin
      // Killed slot: control cleared, data fields simply follow the inputs
      ctrl_d  = '0;
      valid_d = 1'b0;
      rd1_d   = readData1;
      rd2_d   = readData2;
      imm_d   = signExtImm;
      pc_d    = pcPlus4;
      rs_d    = idRs;
      rt_d    = idRt;
      rd_d    = idRd;
    end else if (hold) begin
      ctrl_d = ctrl_q;
    end else if (hazard) begin
      // Bubble: MemRead drops to 0 so the stall releases next cycle
      ctrl_d  = '0;
      valid_d = 1'b0;
    end else begin
      ctrl_d  = idValid ? controlData : 9'd0;
      valid_d = idValid;
      rd1_d   = readData1;
      rd2_d   = readData2;
      imm_d   = signExtImm;
      pc_d    = pcPlus4;
      rs_d    = idRs;
      rt_d    = idRt;
      rd_d    = idRd;
    end
  end

  // Pipeline register state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ctrl_q  <= '0;
      valid_q <= 1'b0;
      rd1_q   <= '0;
      rd2_q   <= '0;
      imm_q   <= '0;
      pc_q    <= '0;
      rs_q    <= '0;
      rt_q    <= '0;
      rd_q    <= '0;
    end else begin
      ctrl_q  <= ctrl_d;
      valid_q <= valid_d;
      rd1_q   <= rd1_d;
      rd2_q   <= rd2_d;
      imm_q   <= imm_d;
      pc_q    <= pc_d;
      rs_q    <= rs_d;
      rt_q    <= rt_d;
      rd_q    <= rd_d;
    end
  end

  assign exControl   = ctrl_q;
  assign exValid     = valid_q;
  assign exReadData1 = rd1_q;
  assign exReadData2 = rd2_q;
  assign exImm       = imm_q;
  assign exPcPlus4   = pc_q;
  assign exRs        = rs_q;
  assign exRt        = rt_q;
  assign exRd        = rd_q;

`ifdef ID_EX_BUBBLE_CNT_EN
  logic [15:0] bcnt_q, bcnt_d;
  logic        bubble;

  // Count only edges that actually insert a hazard bubble, saturating at all-ones
  always_comb begin
    bubble = hazard & ~flush & ~hold;
    bcnt_d = bcnt_q;
    if (bubble && (bcnt_q != 16'hFFFF)) begin
      bcnt_d = bcnt_q + 16'd1;
    end
  end

  // Bubble counter register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bcnt_q <= 16'd0;
    end else begin
      bcnt_q <= bcnt_d;
    end
  end

  assign bubbleCount = bcnt_q;
`else
  assign bubbleCount = 16'h0000;
`endif

endmodule

// File: tb/tb_id_ex_register.sv
// tb/tb_id_ex_register.sv - scoreboard bench for id_ex_register
module tb_id_ex_register;

`ifdef ID_EX_BUBBLE_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  localparam logic [8:0] RT = 9'b100100010;
  localparam logic [8:0] LB = 9'b011110000;

  logic        clk = 1'b0;
  logic        rst;
  logic [8:0]  controlData;
  logic        idValid;
  logic [31:0] readData1, readData2, signExtImm, pcPlus4;
  logic [4:0]  idRs, idRt, idRd;
  logic        flush, hold;
  logic [8:0]  exControl;
  logic        exValid;
  logic [31:0] exReadData1, exReadData2, exImm, exPcPlus4;
  logic [4:0]  exRs, exRt, exRd;
  logic        stall;
  logic [15:0] bubbleCount;

  id_ex_register #(.DATA_W(32), .REG_W(5)) dut (
    .clk(clk), .rst(rst), .controlData(controlData), .idValid(idValid),
    .readData1(readData1), .readData2(readData2), .signExtImm(signExtImm),
    .pcPlus4(pcPlus4), .idRs(idRs), .idRt(idRt), .idRd(idRd),
    .flush(flush), .hold(hold), .exControl(exControl), .exValid(exValid),
    .exReadData1(exReadData1), .exReadData2(exReadData2), .exImm(exImm),
    .exPcPlus4(exPcPlus4), .exRs(exRs), .exRt(exRt), .exRd(exRd),
    .stall(stall), .bubbleCount(bubbleCount)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [8:0]  ctrl;
    logic        valid;
    logic [31:0] r1, r2, imm, pc;
    logic [4:0]  rs, rt, rd;
    logic        stl;
    logic [15:0] bc;
  } exp_t;

  exp_t sb[$];
  exp_t cur;
  int   n_cmp  = 0;
  int   n_fail = 0;

  task automatic chk(input string nm, input string fld, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s.%s actual=%h required=%h", nm, fld, act, req);
    end
  endtask

  // Monitor: whenever an expectation is pending, compare it against the DUT at the falling edge
  always @(negedge clk) begin
    if (sb.size() != 0) begin
      cur = sb.pop_front();
      chk(cur.name, "exControl",   {23'd0, exControl},   {23'd0, cur.ctrl});
      chk(cur.name, "exValid",     {31'd0, exValid},     {31'd0, cur.valid});
      chk(cur.name, "exReadData1", exReadData1,          cur.r1);
      chk(cur.name, "exReadData2", exReadData2,          cur.r2);
      chk(cur.name, "exImm",       exImm,                cur.imm);
      chk(cur.name, "exPcPlus4",   exPcPlus4,            cur.pc);
      chk(cur.name, "exRs",        {27'd0, exRs},        {27'd0, cur.rs});
      chk(cur.name, "exRt",        {27'd0, exRt},        {27'd0, cur.rt});
      chk(cur.name, "exRd",        {27'd0, exRd},        {27'd0, cur.rd});
      chk(cur.name, "stall",       {31'd0, stall},       {31'd0, cur.stl});
      chk(cur.name, "bubbleCount", {16'd0, bubbleCount}, {16'd0, cur.bc});
    end
  end

  task automatic drv(input logic idv, input logic [8:0] c, input logic [31:0] r1, input logic [31:0] r2,
                     input logic [31:0] im, input logic [31:0] pc, input logic [4:0] rs, input logic [4:0] rt,
                     input logic [4:0] rd, input logic fl, input logic ho);
    idValid = idv; controlData = c; readData1 = r1; readData2 = r2; signExtImm = im; pcPlus4 = pc;
    idRs = rs; idRt = rt; idRd = rd; flush = fl; hold = ho;
  endtask

  task automatic expect_out(input string nm, input logic [8:0] c, input logic v, input logic [31:0] r1,
                            input logic [31:0] r2, input logic [31:0] im, input logic [31:0] pc,
                            input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                            input logic st, input logic [15:0] bc);
    exp_t e;
    e.name = nm; e.ctrl = c; e.valid = v; e.r1 = r1; e.r2 = r2; e.imm = im; e.pc = pc;
    e.rs = rs; e.rt = rt; e.rd = rd; e.stl = st; e.bc = CNT_EN ? bc : 16'h0000;
    sb.push_back(e);
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    drv(0, 9'd0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    drv(1, RT, 32'h11, 32'h22, 32'h33, 32'h44, 5'd1, 5'd2, 5'd8, 0, 0);
    expect_out("reset_state", 9'd0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    next_cycle();
    drv(1, LB, 32'h55, 32'h66, 32'h4, 32'h48, 5'd3, 5'd9, 5'd0, 0, 0);
    expect_out("rtype", RT, 1, 32'h11, 32'h22, 32'h33, 32'h44, 5'd1, 5'd2, 5'd8, 0, 0);

    next_cycle();
    drv(1, RT, 32'h77, 32'h88, 32'h5, 32'h4c, 5'd9, 5'd4, 5'd10, 0, 0);
    expect_out("loaduse_stall", LB, 1, 32'h55, 32'h66, 32'h4, 32'h48, 5'd3, 5'd9, 5'd0, 1, 0);

    next_cycle();
    expect_out("bubble", 9'd0, 0, 32'h55, 32'h66, 32'h4, 32'h48, 5'd3, 5'd9, 5'd0, 0, 1);

    next_cycle();
    drv(1, LB, 32'h1, 32'h2, 32'h3, 32'h50, 5'd0, 5'd0, 5'd0, 0, 0);
    expect_out("after_bubble", RT, 1, 32'h77, 32'h88, 32'h5, 32'h4c, 5'd9, 5'd4, 5'd10, 0, 1);

    next_cycle();
    drv(1, RT, 32'ha, 32'hb, 32'hc, 32'h54, 5'd0, 5'd0, 5'd5, 0, 0);
    expect_out("zero_lb", LB, 1, 32'h1, 32'h2, 32'h3, 32'h50, 5'd0, 5'd0, 5'd0, 0, 1);

    next_cycle();
    drv(1, LB, 32'h100, 32'h200, 32'h300, 32'h58, 5'd1, 5'd7, 5'd0, 0, 0);
    expect_out("zero_next", RT, 1, 32'ha, 32'hb, 32'hc, 32'h54, 5'd0, 5'd0, 5'd5, 0, 1);

    next_cycle();
    drv(1, RT, 32'h111, 32'h222, 32'h333, 32'h5c, 5'd7, 5'd2, 5'd3, 1, 0);
    expect_out("flush_hazard", LB, 1, 32'h100, 32'h200, 32'h300, 32'h58, 5'd1, 5'd7, 5'd0, 0, 1);

    next_cycle();
    drv(1, LB, 32'h1, 32'h2, 32'h3, 32'h60, 5'd0, 5'd6, 5'd0, 0, 0);
    expect_out("flush_result", 9'd0, 0, 32'h111, 32'h222, 32'h333, 32'h5c, 5'd7, 5'd2, 5'd3, 0, 1);

    next_cycle();
    drv(1, RT, 32'h9, 32'h9, 32'h9, 32'h64, 5'd6, 5'd1, 5'd2, 0, 1);
    expect_out("hold_c1", LB, 1, 32'h1, 32'h2, 32'h3, 32'h60, 5'd0, 5'd6, 5'd0, 1, 1);

    next_cycle();
    expect_out("hold_c2", LB, 1, 32'h1, 32'h2, 32'h3, 32'h60, 5'd0, 5'd6, 5'd0, 1, 1);

    next_cycle();
    expect_out("hold_c3", LB, 1, 32'h1, 32'h2, 32'h3, 32'h60, 5'd0, 5'd6, 5'd0, 1, 1);

    next_cycle();
    hold = 1'b0;
    expect_out("hold_release", LB, 1, 32'h1, 32'h2, 32'h3, 32'h60, 5'd0, 5'd6, 5'd0, 1, 1);

    next_cycle();
    expect_out("hold_bubble", 9'd0, 0, 32'h1, 32'h2, 32'h3, 32'h60, 5'd0, 5'd6, 5'd0, 0, 2);

    next_cycle();
    drv(0, LB, 32'hdead, 32'hbeef, 32'hf, 32'h68, 5'd1, 5'd1, 5'd1, 0, 0);
    expect_out("reload", RT, 1, 32'h9, 32'h9, 32'h9, 32'h64, 5'd6, 5'd1, 5'd2, 0, 2);

    next_cycle();
    drv(1, RT, 32'h1234, 32'h5678, 32'h9a, 32'h6c, 5'd2, 5'd3, 5'd4, 0, 0);
    expect_out("invalid_id", 9'd0, 0, 32'hdead, 32'hbeef, 32'hf, 32'h68, 5'd1, 5'd1, 5'd1, 0, 2);

    next_cycle();
    expect_out("pre_reset", RT, 1, 32'h1234, 32'h5678, 32'h9a, 32'h6c, 5'd2, 5'd3, 5'd4, 0, 2);

    @(posedge clk);
    #2;
    rst = 1'b1;
    expect_out("async_reset", 9'd0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    next_cycle();
    rst = 1'b0;
    expect_out("reset_release", 9'd0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    next_cycle();
    expect_out("first_load", RT, 1, 32'h1234, 32'h5678, 32'h9a, 32'h6c, 5'd2, 5'd3, 5'd4, 0, 0);

    for (int i = 0; i < 10 && sb.size() != 0; i++) @(negedge clk);
    #1;
    n_cmp++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL drain pending=%0d required=0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

endmodule
